fsm_run_launcher: RTL

Initiator side of the single-cycle run/done handshake used by our FSM worker blocks: the launcher issues one-cycle `o_run` pulses to a worker and waits for its `i_done` response. On a start command it runs the worker a programmed number of times back-to-back, counts completions, and guards every job with a timeout. It sits between a control register/sequencer and any worker block exposing the run/done pair.

---
 rtl/fsm_run_launcher_pkg.sv | 14 +
 rtl/fsm_run_launcher_timeout_timer.sv | 40 ++++
 rtl/fsm_run_launcher.sv | 117 +++++++++++
 3 files changed

// File: rtl/fsm_run_launcher_pkg.sv
// Shared types and constants for the run/done launcher.
package fsm_run_launcher_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_e;

endpackage

// File: rtl/fsm_run_launcher_timeout_timer.sv
// Per-job WAIT cycle counter; saturates at TIMEOUT-1 and flags expiry there.
module timeout_timer
    import fsm_run_launcher_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 100,
    parameter int unsigned TO_WIDTH = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_WIDTH-1:0] LAST = TO_WIDTH'(TIMEOUT - 1);

    logic [TO_WIDTH-1:0] count_q, count_d;

    // Next count: clear wins, otherwise count up until the last value.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LAST)) begin
            count_d = count_q + TO_WIDTH'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/fsm_run_launcher.sv
// Launches N back-to-back worker jobs over the run/done handshake, with a
// per-job timeout. All outputs are registered.
module fsm_run_launcher
    import fsm_run_launcher_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned TIMEOUT   = 100,
    parameter int unsigned TO_WIDTH  = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_start,
    input  logic [CNT_WIDTH-1:0] i_num_jobs,
    input  logic                 i_done,
    output logic                 o_run,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_job_cnt,
    output logic                 o_all_done,
    output logic                 o_timeout
);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] n_q, n_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 run_q, run_d;
    logic                 busy_q, busy_d;
    logic                 all_done_q, all_done_d;
    logic                 timeout_q, timeout_d;
    logic                 timer_clr, timer_en, timer_expired;

    timeout_timer #(
        .TIMEOUT  (TIMEOUT),
        .TO_WIDTH (TO_WIDTH)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // Next-state logic; outputs are decoded from the next state so that each
    // registered output lines up with the state it describes.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    n_d       = i_num_jobs;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = (i_num_jobs == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                timer_clr = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (i_done) begin
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = (cnt_d == n_q) ? DONE : RUN;
                end else if (timer_expired) begin
                    state_d = ERR;
                end else begin
                    timer_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                timeout_d = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        run_d      = (state_d == RUN);
        busy_d     = (state_d == RUN) || (state_d == WAIT);
        all_done_d = (state_d == DONE);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            n_q        <= '0;
            cnt_q      <= '0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            all_done_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            busy_q     <= busy_d;
            all_done_q <= all_done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_run      = run_q;
    assign o_busy     = busy_q;
    assign o_job_cnt  = cnt_q;
    assign o_all_done = all_done_q;
    assign o_timeout  = timeout_q;

endmodule
